rv32im_branch_unit: RTL and testbench

RV32IM_BRANCH_UNIT -- requirements
Module: rv32im_br

---
 rtl/rv32im_branch_unit_pkg.sv | 16 +
 rtl/rv32im_branch_unit_cond.sv | 27 ++
 rtl/rv32im_branch_unit.sv | 57 +++++
 tb/tb_rv32im_branch_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rv32im_branch_unit_pkg.sv
// Shared definitions for the RV32IM branch unit.
// Widths and funct3 branch encodings.
package rv32im_branch_unit_pkg;

  localparam int API_ADDR_WIDTH  = 32;
  localparam int API_DATA_WIDTH  = 32;
  localparam int BR_OPCODE_WIDTH = 3;

  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BEQ  = 3'b000;
  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BNE  = 3'b001;
  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BLT  = 3'b100;
  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BGE  = 3'b101;
  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BLTU = 3'b110;
  localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BGEU = 3'b111;

endpackage

// File: rtl/rv32im_branch_unit_cond.sv
// Branch condition evaluation from ALU flags.
// Invalid funct3 values (010/011) evaluate as not taken.
module rv32im_branch_unit_cond
  import rv32im_branch_unit_pkg::*;
(
  input  logic                       alu_zero_i,
  input  logic                       res_msb_i,
  input  logic                       res_lsb_i,
  input  logic [BR_OPCODE_WIDTH-1:0] br_opcode_i,
  output logic                       cond_taken_o
);

  // Select the flag relevant to the branch type
  always_comb begin
    cond_taken_o = 1'b0;
    unique case (1'b1)
      (br_opcode_i == BR_OPCODE_BEQ):  cond_taken_o = alu_zero_i;
      (br_opcode_i == BR_OPCODE_BNE):  cond_taken_o = !alu_zero_i;
      (br_opcode_i == BR_OPCODE_BLT):  cond_taken_o = res_msb_i;
      (br_opcode_i == BR_OPCODE_BGE):  cond_taken_o = !res_msb_i;
      (br_opcode_i == BR_OPCODE_BLTU): cond_taken_o = res_lsb_i;
      (br_opcode_i == BR_OPCODE_BGEU): cond_taken_o = !res_lsb_i;
      default:                         cond_taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32im_branch_unit.sv
// RV32IM branch unit: taken decision and next fetch PC.
// Outputs are combinational; only the taken flag is also registered.
module rv32im_branch_unit #(
  parameter int API_ADDR_WIDTH  = rv32im_branch_unit_pkg::API_ADDR_WIDTH,
  parameter int API_DATA_WIDTH  = rv32im_branch_unit_pkg::API_DATA_WIDTH,
  parameter int BR_OPCODE_WIDTH = rv32im_branch_unit_pkg::BR_OPCODE_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       br_en_i,
  input  logic                       br_conditional_i,
  input  logic                       alu_zero_i,
  input  logic [API_ADDR_WIDTH-1:0]  exu_calc_addr,
  input  logic [BR_OPCODE_WIDTH-1:0] br_opcode_i,
  input  logic [API_ADDR_WIDTH-1:0]  curr_pc_i,
  input  logic [API_DATA_WIDTH-1:0]  imm_i,
  output logic [API_ADDR_WIDTH-1:0]  br_pc_o,
  output logic [API_ADDR_WIDTH-1:0]  nxt_pc_o,
  output logic                       br_taken_o,
  output logic                       br_taken_q_o
);

  logic                      cond_taken;
  logic [API_ADDR_WIDTH-1:0] cond_tgt;
  logic [API_ADDR_WIDTH-1:0] jump_tgt;

  rv32im_branch_unit_cond u_cond (
    .alu_zero_i   (alu_zero_i),
    .res_msb_i    (exu_calc_addr[API_ADDR_WIDTH-1]),
    .res_lsb_i    (exu_calc_addr[0]),
    .br_opcode_i  (br_opcode_i),
    .cond_taken_o (cond_taken)
  );

  assign nxt_pc_o = curr_pc_i + API_ADDR_WIDTH'(4);
  assign cond_tgt = curr_pc_i + API_ADDR_WIDTH'(imm_i);
  assign jump_tgt = {exu_calc_addr[API_ADDR_WIDTH-1:1], 1'b0};

  // Taken decision and target mux
  always_comb begin
    br_taken_o = br_en_i && (!br_conditional_i || cond_taken);
    br_pc_o    = nxt_pc_o;
    if (br_taken_o) begin
      br_pc_o = br_conditional_i ? cond_tgt : jump_tgt;
    end
  end

  // Registered copy of the taken decision
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_taken_q_o <= 1'b0;
    end else begin
      br_taken_q_o <= br_taken_o;
    end
  end

endmodule

// File: tb/tb_rv32im_branch_unit.sv
// Self-checking bench for rv32im_branch_unit.
// Directed vectors plus random stimulus against a reference model.
module tb_rv32im_branch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        br_en_i;
  logic        br_conditional_i;
  logic        alu_zero_i;
  logic [31:0] exu_calc_addr;
  logic [2:0]  br_opcode_i;
  logic [31:0] curr_pc_i;
  logic [31:0] imm_i;
  logic [31:0] br_pc_o;
  logic [31:0] nxt_pc_o;
  logic        br_taken_o;
  logic        br_taken_q_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  rv32im_branch_unit dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .br_en_i          (br_en_i),
    .br_conditional_i (br_conditional_i),
    .alu_zero_i       (alu_zero_i),
    .exu_calc_addr    (exu_calc_addr),
    .br_opcode_i      (br_opcode_i),
    .curr_pc_i        (curr_pc_i),
    .imm_i            (imm_i),
    .br_pc_o          (br_pc_o),
    .nxt_pc_o         (nxt_pc_o),
    .br_taken_o       (br_taken_o),
    .br_taken_q_o     (br_taken_q_o)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_taken(bit en, bit cnd, bit zero,
                                   logic [31:0] res, logic [2:0] op);
    int signed sres;
    if (!en) return 0;
    if (!cnd) return 1;
    sres = $signed(res);
    case (op)
      3'd0: return zero;
      3'd1: return !zero;
      3'd4: return sres < 0;
      3'd5: return sres >= 0;
      3'd6: return (res % 2) == 1;
      3'd7: return (res % 2) == 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_pc(bit en, bit cnd, bit zero,
                                         logic [31:0] res, logic [2:0] op,
                                         logic [31:0] pc, logic [31:0] imm);
    if (!ref_taken(en, cnd, zero, res, op)) return pc + 32'd4;
    if (cnd) return pc + imm;
    return res - (res % 2);
  endfunction

  task automatic drive(bit en, bit cnd, bit zero, logic [31:0] res,
                       logic [2:0] op, logic [31:0] pc, logic [31:0] imm);
    br_en_i          = en;
    br_conditional_i = cnd;
    alu_zero_i       = zero;
    exu_calc_addr    = res;
    br_opcode_i      = op;
    curr_pc_i        = pc;
    imm_i            = imm;
  endtask

  task automatic run_vec(input string tag, bit en, bit cnd, bit zero,
                         logic [31:0] res, logic [2:0] op,
                         logic [31:0] pc, logic [31:0] imm);
    bit tk;
    @(negedge clk_i);
    drive(en, cnd, zero, res, op, pc, imm);
    #1;
    tk = ref_taken(en, cnd, zero, res, op);
    check({tag, ".pc"}, br_pc_o, ref_pc(en, cnd, zero, res, op, pc, imm));
    check({tag, ".nxt"}, nxt_pc_o, pc + 32'd4);
    check({tag, ".tk"}, 32'(br_taken_o), 32'(tk));
    @(posedge clk_i);
    #1;
    check({tag, ".q"}, 32'(br_taken_q_o), 32'(tk));
  endtask

  task automatic dir(input string tag, bit en, bit cnd, bit zero,
                     logic [31:0] res, logic [2:0] op, logic [31:0] pc,
                     logic [31:0] imm, logic [31:0] exp_pc, bit exp_tk);
    @(negedge clk_i);
    drive(en, cnd, zero, res, op, pc, imm);
    #1;
    check({tag, ".pc"}, br_pc_o, exp_pc);
    check({tag, ".tk"}, 32'(br_taken_o), 32'(exp_tk));
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 32'h0, 3'd0, 32'h100, 32'h0);
    #2;
    check("rst.q", 32'(br_taken_q_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    dir("jal", 1, 0, 0, 32'hFFEEDDCC, 3'd0, 32'h001FFFF3, 32'h0,
        32'hFFEEDDCC, 1);
    check("jal.nxt", nxt_pc_o, 32'h001FFFF7);
    dir("jalr_lsb", 1, 0, 1, 32'h00001235, 3'd2, 32'h10, 32'h0,
        32'h00001234, 1);
    dir("beq_nt", 1, 1, 0, 32'h1, 3'd0, 32'h001FFFF3, 32'h00ABCDEF,
        32'h001FFFF7, 0);
    dir("beq_t", 1, 1, 1, 32'h0, 3'd0, 32'h001FFFF3, 32'h00ABCDEF,
        32'h00CBCDE2, 1);
    dir("bne_nt", 1, 1, 1, 32'h0, 3'd1, 32'h3, 32'h00ABCDEE,
        32'h00000007, 0);
    dir("bne_t", 1, 1, 0, 32'h5, 3'd1, 32'h3, 32'h00ABCDEE,
        32'h00ABCDF1, 1);
    dir("blt_p9", 1, 1, 0, 32'd9, 3'd4, 32'h0, 32'h40, 32'h4, 0);
    dir("bge_p9", 1, 1, 0, 32'd9, 3'd5, 32'h0, 32'h40, 32'h40, 1);
    dir("blt_m9", 1, 1, 0, 32'hFFFFFFF7, 3'd4, 32'h0, 32'h40, 32'h40, 1);
    dir("bge_m9", 1, 1, 0, 32'hFFFFFFF7, 3'd5, 32'h0, 32'h40, 32'h4, 0);
    dir("bge_0", 1, 1, 1, 32'h0, 3'd5, 32'h0, 32'h40, 32'h40, 1);
    dir("bltu_0", 1, 1, 1, 32'h0, 3'd6, 32'h0, 32'h40, 32'h4, 0);
    dir("bgeu_0", 1, 1, 1, 32'h0, 3'd7, 32'h0, 32'h40, 32'h40, 1);
    dir("bltu_1", 1, 1, 0, 32'h1, 3'd6, 32'h0, 32'h40, 32'h40, 1);
    dir("bgeu_1", 1, 1, 0, 32'h1, 3'd7, 32'h0, 32'h40, 32'h4, 0);
    dir("inv_010", 1, 1, 1, 32'h1, 3'd2, 32'h0, 32'h40, 32'h4, 0);
    dir("inv_011", 1, 1, 1, 32'h0, 3'd3, 32'h0, 32'h40, 32'h4, 0);
    dir("wrap", 1, 1, 1, 32'h0, 3'd0, 32'hFFFFFFFC, 32'h8, 32'h4, 1);
    check("wrap.nxt", nxt_pc_o, 32'h0);

    run_vec("pre_rst", 1, 0, 0, 32'h00008000, 3'd0, 32'h200, 32'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst.q", 32'(br_taken_q_o), 32'h0);
    check("arst.tk", 32'(br_taken_o), 32'h1);
    check("arst.pc", br_pc_o, 32'h00008000);
    @(posedge clk_i);
    #1;
    check("arst_hold.q", 32'(br_taken_q_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("rel.q", 32'(br_taken_q_o), 32'h0);
    @(posedge clk_i);
    #1;
    check("rel_edge.q", 32'(br_taken_q_o), 32'h1);
    dir("en0", 0, 0, 1, 32'h12345678, 3'd0, 32'h00400000, 32'h100,
        32'h00400004, 0);
    @(posedge clk_i);
    #1;
    check("en0.q", 32'(br_taken_q_o), 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] res;
      logic [2:0]  op;
      bit          en;
      bit          cnd;
      bit          zero;
      res  = $urandom;
      if ($urandom_range(0, 3) == 0) res = $urandom_range(0, 3);
      op   = 3'($urandom_range(0, 7));
      en   = ($urandom_range(0, 7) != 0);
      cnd  = ($urandom_range(0, 3) != 0);
      zero = (res == 0) ^ ($urandom_range(0, 9) == 0);
      run_vec("rnd", en, cnd, zero, res, op, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
